// File: rtl/cpu_interrupt_acknowledge_sequencer_pkg.sv
// Shared definitions for the 8259A INTA initiator: FSM states, CALL opcode and mode encodings.
package cpu_interrupt_acknowledge_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PULSE_LOW  = 2'd1,
    PULSE_HIGH = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic       MODE_8086   = 1'b1;
  localparam logic       MODE_MCS80  = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cpu_interrupt_acknowledge_sequencer_inta_phase_timer.sv
// Down-counting phase timer: loaded with (length-1) on phase entry, flags the last cycle of the phase.
module inta_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] load_value,
  output logic             phase_done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign phase_done = run && (count == '0);

endmodule

// File: rtl/cpu_interrupt_acknowledge_sequencer.sv
// CPU-side 8259A INTA initiator: drives 2 (8086) or 3 (MCS-80) INTA# pulses, samples the PIC bytes,
// and hands the vector / CALL address to the core via a valid/taken handshake.
//
// state      | meaning
// IDLE       | waiting for INT & IF with no result pending
// PULSE_LOW  | INTA# low, PIC drives data_bus; byte sampled at the closing edge
// PULSE_HIGH | INTA# high between pulses, bus still locked
// DONE       | result valid, waiting for vector_taken
module cpu_interrupt_acknowledge_sequencer
  import cpu_interrupt_acknowledge_sequencer_pkg::*;
#(
  parameter int INTA_LOW_CYCLES  = 4,
  parameter int INTA_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_request,
  input  logic        interrupt_enable,
  input  logic        u8086_or_mcs80_config,
  input  logic [7:0]  data_bus,
  input  logic        vector_taken,
  output logic        interrupt_acknowledge_n,
  output logic        bus_lock,
  output logic        busy,
  output logic        vector_valid,
  output logic [7:0]  interrupt_vector,
  output logic [15:0] call_address,
  output logic        call_opcode_error
);

  localparam int CNT_W = $clog2(max_int(INTA_LOW_CYCLES, INTA_HIGH_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(INTA_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(INTA_HIGH_CYCLES - 1);

  state_t      state, state_d;
  logic        mode, mode_d;
  logic [1:0]  pulse_index, pulse_index_d;
  logic [7:0]  low_byte, low_byte_d;
  logic        inta_n_d, bus_lock_d, valid_d, err_d;
  logic [7:0]  vector_d;
  logic [15:0] call_d;
  logic        timer_load, timer_run, phase_done, last_pulse;
  logic [CNT_W-1:0] timer_value;

  inta_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load),
    .run        (timer_run),
    .load_value (timer_value),
    .phase_done (phase_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      mode                    <= MODE_8086;
      pulse_index             <= 2'd0;
      low_byte                <= 8'h00;
      interrupt_acknowledge_n <= 1'b1;
      bus_lock                <= 1'b0;
      vector_valid            <= 1'b0;
      interrupt_vector        <= 8'h00;
      call_address            <= 16'h0000;
      call_opcode_error       <= 1'b0;
    end else begin
      state                   <= state_d;
      mode                    <= mode_d;
      pulse_index             <= pulse_index_d;
      low_byte                <= low_byte_d;
      interrupt_acknowledge_n <= inta_n_d;
      bus_lock                <= bus_lock_d;
      vector_valid            <= valid_d;
      interrupt_vector        <= vector_d;
      call_address            <= call_d;
      call_opcode_error       <= err_d;
    end
  end

  assign last_pulse = (mode == MODE_8086) ? (pulse_index == 2'd1) : (pulse_index == 2'd2);
  assign timer_run  = (state == PULSE_LOW) || (state == PULSE_HIGH);
  assign busy       = (state != IDLE);

  always_comb begin
    state_d       = state;
    mode_d        = mode;
    pulse_index_d = pulse_index;
    low_byte_d    = low_byte;
    inta_n_d      = interrupt_acknowledge_n;
    bus_lock_d    = bus_lock;
    valid_d       = vector_valid;
    vector_d      = interrupt_vector;
    call_d        = call_address;
    err_d         = call_opcode_error;
    timer_load    = 1'b0;
    timer_value   = LOW_LOAD;

    unique case (state)
      IDLE: begin
        if (interrupt_request && interrupt_enable && !vector_valid) begin
          state_d       = PULSE_LOW;
          mode_d        = u8086_or_mcs80_config;
          pulse_index_d = 2'd0;
          err_d         = 1'b0;
          inta_n_d      = 1'b0;
          bus_lock_d    = 1'b1;
          timer_load    = 1'b1;
          timer_value   = LOW_LOAD;
        end
      end
      PULSE_LOW: begin
        if (phase_done) begin
          inta_n_d = 1'b1;
          if ((pulse_index == 2'd0) && (mode == MODE_MCS80)) begin
            err_d = (data_bus != CALL_OPCODE);
          end
          if (pulse_index == 2'd1) begin
            low_byte_d = data_bus;
          end
          if (last_pulse) begin
            state_d    = DONE;
            bus_lock_d = 1'b0;
            valid_d    = 1'b1;
            // 8086 ends on pulse 2, so the byte on the bus right now is the vector
            if (mode == MODE_8086) begin
              vector_d = data_bus;
              call_d   = {8'h00, data_bus};
            end else begin
              vector_d = low_byte;
              call_d   = {data_bus, low_byte};
            end
          end else begin
            state_d     = PULSE_HIGH;
            timer_load  = 1'b1;
            timer_value = HIGH_LOAD;
          end
        end
      end
      PULSE_HIGH: begin
        if (phase_done) begin
          state_d       = PULSE_LOW;
          pulse_index_d = pulse_index + 2'd1;
          inta_n_d      = 1'b0;
          timer_load    = 1'b1;
          timer_value   = LOW_LOAD;
        end
      end
      DONE: begin
        if (vector_taken) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_interrupt_acknowledge_sequencer.sv
// Directed bench for the INTA sequencer with a result scoreboard and pulse-shape checks.
module tb_cpu_interrupt_acknowledge_sequencer;
  import cpu_interrupt_acknowledge_sequencer_pkg::*;

  localparam int L = 4;
  localparam int H = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        interrupt_request, interrupt_enable, u8086_or_mcs80_config, vector_taken;
  logic [7:0]  data_bus;
  logic        interrupt_acknowledge_n, bus_lock, busy, vector_valid, call_opcode_error;
  logic [7:0]  interrupt_vector;
  logic [15:0] call_address;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  vec;
    logic [15:0] call;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  cpu_interrupt_acknowledge_sequencer #(
    .INTA_LOW_CYCLES (L),
    .INTA_HIGH_CYCLES(H)
  ) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .interrupt_request      (interrupt_request),
    .interrupt_enable       (interrupt_enable),
    .u8086_or_mcs80_config  (u8086_or_mcs80_config),
    .data_bus               (data_bus),
    .vector_taken           (vector_taken),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .bus_lock               (bus_lock),
    .busy                   (busy),
    .vector_valid           (vector_valid),
    .interrupt_vector       (interrupt_vector),
    .call_address           (call_address),
    .call_opcode_error      (call_opcode_error)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inta_n"}, interrupt_acknowledge_n, 1);
    check({tag, "_bus_lock"}, bus_lock, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, vector_valid, 0);
    check({tag, "_vector"}, interrupt_vector, 0);
    check({tag, "_call"}, call_address, 0);
    check({tag, "_err"}, call_opcode_error, 0);
  endtask

  // disturb: drop INT, flip mode and poke vector_taken mid-sequence
  // restart: hold INT through DONE, delay the handshake, expect an immediate restart
  task automatic run_seq(input string tag, input logic mode, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input bit disturb, input bit restart);
    exp_t        e;
    logic [7:0]  bytes [3];
    logic [31:0] pat_obs, pat_exp;
    int          k, idx;
    bit          bl_ok, hold_ok;
    bytes  = '{b0, b1, b2};
    e.vec  = b1;
    e.call = (mode == MODE_8086) ? {8'h00, b1} : {b2, b1};
    e.err  = (mode == MODE_MCS80) && (b0 != CALL_OPCODE);
    e.lat  = (mode == MODE_8086) ? (2 * L + H) : (3 * L + 2 * H);
    sb.push_back(e);
    pat_exp = '0;
    for (int i = 0; i < e.lat; i++) if ((i % (L + H)) >= L) pat_exp[i] = 1'b1;

    u8086_or_mcs80_config = mode;
    interrupt_request     = 1'b1;
    interrupt_enable      = 1'b1;
    data_bus              = b0;
    tick();
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_err_clear"}, call_opcode_error, 0);

    k = 0; pat_obs = '0; bl_ok = 1'b1;
    while ((vector_valid !== 1'b1) && (k < 40)) begin
      if (k < 32) pat_obs[k] = interrupt_acknowledge_n;
      if (bus_lock !== 1'b1) bl_ok = 1'b0;
      if (disturb) begin
        if (k == 1) begin
          interrupt_request     = 1'b0;
          u8086_or_mcs80_config = ~mode;
        end
        vector_taken = (k == 3);
      end
      idx = k / (L + H);
      data_bus = bytes[(idx > 2) ? 2 : idx];
      tick();
      k++;
    end
    vector_taken = 1'b0;
    check({tag, "_latency"}, k, e.lat);
    check({tag, "_inta_pattern"}, pat_obs, pat_exp);
    check({tag, "_bus_lock_held"}, bl_ok, 1);

    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_vector"}, interrupt_vector, e.vec);
      check({tag, "_call"}, call_address, e.call);
      check({tag, "_err"}, call_opcode_error, e.err);
      check({tag, "_done_inta_n"}, interrupt_acknowledge_n, 1);
      check({tag, "_done_bus_lock"}, bus_lock, 0);
    end

    if (restart) begin
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if ((vector_valid !== 1'b1) || (interrupt_acknowledge_n !== 1'b1)) hold_ok = 1'b0;
      end
      check({tag, "_hold_no_restart"}, hold_ok, 1);
      vector_taken = 1'b1;
      tick();
      vector_taken = 1'b0;
      check({tag, "_taken_valid"}, vector_valid, 0);
      check({tag, "_taken_idle"}, busy, 0);
      tick();
      check({tag, "_restart_inta_n"}, interrupt_acknowledge_n, 0);
      check({tag, "_restart_busy"}, busy, 1);
    end else begin
      interrupt_request = 1'b0;
      vector_taken      = 1'b1;
      tick();
      vector_taken = 1'b0;
      check({tag, "_taken_valid"}, vector_valid, 0);
      check({tag, "_taken_idle"}, busy, 0);
      check({tag, "_idle_vector_held"}, interrupt_vector, e.vec);
      check({tag, "_idle_call_held"}, call_address, e.call);
      check({tag, "_idle_err_held"}, call_opcode_error, e.err);
    end
  endtask

  initial begin
    bit gate_ok;
    reset_n               = 1'b0;
    interrupt_request     = 1'b0;
    interrupt_enable      = 1'b0;
    u8086_or_mcs80_config = MODE_8086;
    vector_taken          = 1'b0;
    data_bus              = 8'h00;
    tick();
    tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    interrupt_request = 1'b1;
    gate_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((interrupt_acknowledge_n !== 1'b1) || (busy !== 1'b0)) gate_ok = 1'b0;
    end
    check("if_gate_idle", gate_ok, 1);

    run_seq("m8086", MODE_8086, 8'hFF, 8'h48, 8'h00, 1'b0, 1'b0);
    run_seq("mcs80", MODE_MCS80, 8'hCD, 8'h40, 8'h12, 1'b0, 1'b0);
    run_seq("mcs80_badop", MODE_MCS80, 8'hC3, 8'h40, 8'h12, 1'b0, 1'b0);
    run_seq("spurious", MODE_8086, 8'h00, 8'h4F, 8'h00, 1'b1, 1'b0);
    run_seq("hold", MODE_MCS80, 8'hCD, 8'h34, 8'h56, 1'b0, 1'b1);

    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midpulse_reset");
    interrupt_request = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
